dpcm_arbiter: RTL and testbench

Shares a single DPCM difference engine between NCH independent sample streams. Each channel presents 32-bit words over a valid/ready handshake. The block arbitrates between channels and keeps a per-channel history word. It emits the unsigned absolute difference between each channel's new word and that channel's previous word, tagged with the channel index, on a backpressured output port. It sits between the multi-channel capture front end and the downstream packer.

---
 rtl/dpcm_arbiter.sv | 127 ++++++++++++
 tb/tb_dpcm_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dpcm_arbiter.sv
// Round-robin arbiter sharing one DPCM absolute-difference engine across NCH streams.
// Define DPCM_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module dpcm_arbiter #(
  parameter int NCH = 4,
  parameter int W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*W-1:0]        req_data,
  output logic [NCH-1:0]          req_ready,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic [$clog2(NCH)-1:0]  out_chan,
  input  logic                    out_ready
);

  localparam int CW = $clog2(NCH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_grant;
  logic [W-1:0]  r_cur;
  logic [W-1:0]  r_hist [NCH];
  logic [W-1:0]  r_outData;
  logic [CW-1:0] r_outChan;

  logic [W-1:0]  w_words [NCH];
  logic [CW-1:0] w_winner;
  logic [W-1:0]  w_histG;
  logic [W-1:0]  w_diff;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_words[i] = req_data[i*W +: W];
    end
  end

`ifdef DPCM_FIXED_PRIO_EN
  always_comb begin
    w_winner = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_valid[k]) w_winner = CW'(k);
    end
  end
`else
  logic [CW-1:0] r_ptr;

  // Scan downward so the asserted channel closest above the pointer is assigned last.
  always_comb begin
    int idx;
    idx      = 0;
    w_winner = r_ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req_valid[idx]) w_winner = CW'(idx);
    end
  end
`endif

  assign w_histG = r_hist[r_grant];
  assign w_diff  = (r_cur > w_histG) ? (r_cur - w_histG) : (w_histG - r_cur);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req_ready[i] = (r_state == GRANT) && (r_grant == CW'(i));
    end
  end

  assign out_valid = (r_state == OUT);
  assign out_data  = r_outData;
  assign out_chan  = r_outChan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_cur     <= '0;
      r_outData <= '0;
      r_outChan <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_hist[i] <= '0;
      end
`ifndef DPCM_FIXED_PRIO_EN
      r_ptr     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_grant <= w_winner;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (req_valid[r_grant]) begin
            r_cur   <= w_words[r_grant];
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_hist[r_grant] <= r_cur;
          r_outData       <= w_diff;
          r_outChan       <= r_grant;
          r_state         <= OUT;
        end
        OUT: begin
          if (out_ready) begin
`ifndef DPCM_FIXED_PRIO_EN
            r_ptr <= (r_grant == CW'(NCH - 1)) ? '0 : r_grant + 1'b1;
`endif
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpcm_arbiter.sv
// Directed self-checking bench for dpcm_arbiter: vector table plus hand-written corner sequences.
// Honours DPCM_FIXED_PRIO_EN when computing expected grant order.
module tb_dpcm_arbiter;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic               clk;
  logic               rst;
  logic [NCH-1:0]     req_valid;
  logic [NCH*W-1:0]   req_data;
  logic [NCH-1:0]     req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic [1:0]         out_chan;
  logic               out_ready;

  int checksTotal;
  int checksPassed;

  typedef struct {
    int          chan;
    logic [31:0] data;
    int          expChan;
    logic [31:0] expData;
  } vectorT;

  vectorT vecs [8];

  dpcm_arbiter #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, " out_data"},  out_data,        32'd0);
    checkOutput({name, " out_chan"},  32'(out_chan),  32'd0);
  endtask

  task automatic applyStimulus(input int chan, input logic [31:0] data);
    req_data[chan*W +: W] = data;
    req_valid[chan]       = 1'b1;
  endtask

  // Runs one transaction from IDLE: grant, capture, result, optional backpressure, completion.
  task automatic serveOne(input int expChan, input logic [31:0] expData, input int hold,
                          input bit dropAfter, input string name);
    int cycles;
    int g;
    bit seen;
    cycles    = 0;
    g         = 0;
    seen      = 1'b0;
    out_ready = (hold == 0);
    while (!seen && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (req_ready != '0) seen = 1'b1;
    end
    checkOutput({name, " grant"}, 32'(req_ready), 32'(1) << expChan);
    if (!seen) return;
    for (int i = 0; i < NCH; i++) begin
      if (req_ready[i]) g = i;
    end
    @(posedge clk); #1;
    cycles++;
    if (dropAfter) req_valid[g] = 1'b0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'd3);
    checkOutput({name, " chan"}, 32'(out_chan), 32'(expChan));
    checkOutput({name, " data"}, out_data, expData);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput({name, " hold valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, " hold data"},  out_data,       expData);
      checkOutput({name, " hold chan"},  32'(out_chan),  32'(expChan));
      checkOutput({name, " hold ready"}, 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, " done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int expChan;
    logic [31:0] expData;

    checksTotal  = 0;
    checksPassed = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;

    vecs[0] = '{chan: 1, data: 32'd100,        expChan: 1, expData: 32'd100};
    vecs[1] = '{chan: 1, data: 32'd40,         expChan: 1, expData: 32'd60};
    vecs[2] = '{chan: 0, data: 32'd5,          expChan: 0, expData: 32'd5};
    vecs[3] = '{chan: 0, data: 32'd5,          expChan: 0, expData: 32'd0};
    vecs[4] = '{chan: 0, data: 32'hFFFF_FFFF,  expChan: 0, expData: 32'hFFFF_FFFA};
    vecs[5] = '{chan: 2, data: 32'd1000,       expChan: 2, expData: 32'd1000};
    vecs[6] = '{chan: 3, data: 32'd7,          expChan: 3, expData: 32'd7};
    vecs[7] = '{chan: 3, data: 32'd3,          expChan: 3, expData: 32'd4};

    repeat (2) @(posedge clk);
    #1;
    resetDut();
    checkReset("reset");

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].chan, vecs[v].data);
      serveOne(vecs[v].expChan, vecs[v].expData, 0, 1'b1, $sformatf("vec%0d", v));
    end

    // Backpressure: ch1 history is 40, so 50 yields 10.
    applyStimulus(1, 32'd50);
    serveOne(1, 32'd10, 5, 1'b1, "backpressure");

    // Withdrawal of ch2 during GRANT.
    applyStimulus(2, 32'd999);
    @(posedge clk); #1;
    checkOutput("withdraw grant", 32'(req_ready), 32'b0100);
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    checkOutput("withdraw ready drop", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("withdraw no output", 32'(out_valid), 32'd0);
    applyStimulus(2, 32'd1005);
    applyStimulus(3, 32'd13);
    serveOne(2, 32'd5, 0, 1'b1, "post-withdraw ch2");
    serveOne(3, 32'd10, 0, 1'b1, "post-withdraw ch3");

    // Reset while ch3 is in CALC.
    resetDut();
    checkReset("reset2");
    applyStimulus(3, 32'd50);
    serveOne(3, 32'd50, 0, 1'b1, "pre-midcalc ch3");
    applyStimulus(3, 32'd9);
    @(posedge clk); #1;
    checkOutput("midcalc grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkReset("midcalc");
    applyStimulus(3, 32'd7);
    serveOne(3, 32'd7, 0, 1'b1, "post-midcalc ch3");

    // All channels requesting continuously with constant values.
    resetDut();
    for (int i = 0; i < NCH; i++) begin
      applyStimulus(i, 32'(10 * (i + 1)));
    end
    for (int t = 0; t < 8; t++) begin
`ifdef DPCM_FIXED_PRIO_EN
      expChan = 0;
      expData = (t == 0) ? 32'd10 : 32'd0;
`else
      expChan = t % NCH;
      expData = (t < NCH) ? 32'(10 * (t + 1)) : 32'd0;
`endif
      serveOne(expChan, expData, 0, 1'b0, $sformatf("all4 t%0d", t));
    end
    req_valid = '0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
